// File: rtl/ifetch_prefetch_q.sv
// ifetch_prefetch_q
// -----------------
// Instruction fetch unit: program counter, one outstanding request to a
// synchronous instruction ROM (one-cycle read latency), and a small FIFO
// that buffers returned words with their PCs for decode.
//
// A redirect (taken branch, jump, jal, jr) flushes the FIFO, squashes the
// response of any request in flight, and reloads the PC. Reset has the
// same effect with RESET_PC as the target.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr  ROM read enable and word address (fetch_pc[IMEM_AW+1:2])
//   imem_rdata          ROM data, valid the cycle after imem_req
//   redirect_valid/_target  new byte PC; target bits [1:0] are ignored
//   out_valid/out_ready valid/ready handshake towards decode
//   out_instr/out_pc    instruction word and byte PC at the FIFO head
//   out_pc_plus4        out_pc + 4, wrapping modulo 2^ADDR_W
//   out_link_word       (out_pc + 4) >> 2, word-addressed link value
//   fetch_pc            next byte PC to be requested
//   occupancy           number of queued entries
module ifetch_prefetch_q #(
  parameter int              ADDR_W   = 32,
  parameter int              IMEM_AW  = 14,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [IMEM_AW-1:0]       imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_pc_plus4,
  output logic [ADDR_W-1:0]        out_link_word,
  output logic [ADDR_W-1:0]        fetch_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One extra bit so count + inflight never overflows in the space test.
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // Architectural state.
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // FIFO storage, one register pair per entry.
  logic [31:0]       entry_instr_q [DEPTH];
  logic [ADDR_W-1:0] entry_pc_q    [DEPTH];

  logic              pop;
  logic              wr_en;
  logic [CNT_W:0]    committed;
  logic              space_ok;
  logic [ADDR_W-1:0] head_pc;
  logic [ADDR_W-1:0] head_pc_plus4;
  logic [31:0]       head_instr;

  // Target bits [1:0] are architecturally ignored.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target[1:0];

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  // A returning word is kept unless this cycle flushes the pipeline.
  assign wr_en     = inflight_q && !reset && !redirect_valid;

  // Slots already claimed (queued + in flight) after this cycle's pop;
  // a pop this cycle frees a slot for an issue in the same cycle, which
  // is what sustains one instruction per cycle.
  assign committed = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign space_ok  = (committed < DEPTH_C);

  assign imem_req  = !reset && !redirect_valid && space_ok;
  assign imem_addr = fetch_pc_q[IMEM_AW+1:2];
  assign fetch_pc  = fetch_pc_q;
  assign occupancy = count_q;

  // Head view; forced to zero while empty so idle outputs are deterministic.
  assign head_pc       = entry_pc_q[head_q];
  assign head_instr    = entry_instr_q[head_q];
  assign head_pc_plus4 = head_pc + PC_STEP;

  assign out_pc        = out_valid ? head_pc : '0;
  assign out_instr     = out_valid ? head_instr : '0;
  assign out_pc_plus4  = out_valid ? head_pc_plus4 : '0;
  assign out_link_word = out_valid ? (head_pc_plus4 >> 2) : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    req_pc_d   = req_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (reset) begin
      fetch_pc_d = RESET_PC;
      inflight_d = 1'b0;
      req_pc_d   = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else if (redirect_valid) begin
      // Flush wins over any pop or returning word this cycle.
      fetch_pc_d = {redirect_target[ADDR_W-1:2], 2'b00};
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      // The ROM always answers the next cycle, so in-flight simply
      // tracks whether a request was issued this cycle.
      inflight_d = imem_req;
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
        req_pc_d   = fetch_pc_q;
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (wr_en) begin
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    fetch_pc_q <= fetch_pc_d;
    inflight_q <= inflight_d;
    req_pc_q   <= req_pc_d;
    head_q     <= head_d;
    tail_q     <= tail_d;
    count_q    <= count_d;
  end

  // Entry storage needs no reset: it is only observed while count_q says
  // the entry is live, and every live entry was written first.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clock) begin
      if (wr_en && (tail_q == PTR_W'(gi))) begin
        entry_instr_q[gi] <= imem_rdata;
        entry_pc_q[gi]    <= req_pc_q;
      end
    end
  end

endmodule
